// File: rtl/vgacpu_pkg.sv
// Shared framebuffer geometry and pixel/address types.
// Also holds the write-arbiter FSM state encoding.
package vgacpu_pkg;

  localparam int FB_WIDTH  = 214;
  localparam int FB_HEIGHT = 160;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;

  typedef logic [15:0] fb_addr_t;
  typedef logic [2:0]  pixel_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } arb_state_e;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Valid/ready pixel write channel into the framebuffer arbiter.
// master = requester (CPU or rasterizer), slave = arbiter.
interface fb_write_arbiter_if #(
  parameter int A_WIDTH = 16,
  parameter int D_WIDTH = 3
);

  logic               valid;
  logic               ready;
  logic [A_WIDTH-1:0] addr;
  logic [D_WIDTH-1:0] pixel;

  modport master (
    output valid,
    output addr,
    output pixel,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    input  pixel,
    output ready
  );

endinterface

// File: rtl/fb_rr_arbiter2.sv
// Two-requester round-robin grant with last-winner pointer.
// Bit 0 = CPU, bit 1 = rasterizer; pointer resets to "rast last".
module fb_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_last_rast;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11)
        o_gnt = r_last_rast ? 2'b01 : 2'b10;
      else
        o_gnt = i_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_last_rast <= 1'b1;
    else if (|o_gnt)
      r_last_rast <= o_gnt[1];
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port owner: CPU/rasterizer arbitration + clear sweep.
// Define VGACPU_FB_ARB_STATS_EN to add drop/clear statistics outputs.
module fb_write_arbiter #(
  parameter int FB_WIDTH  = vgacpu_pkg::FB_WIDTH,
  parameter int FB_HEIGHT = vgacpu_pkg::FB_HEIGHT,
  parameter int A_WIDTH   = 16,
  parameter int D_WIDTH   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear_req,
  input  logic [D_WIDTH-1:0] i_clear_colour,
  output logic               o_clear_busy,
  fb_write_arbiter_if.slave  cpu_wr,
  fb_write_arbiter_if.slave  rast_wr,
`ifdef VGACPU_FB_ARB_STATS_EN
  output logic [15:0]        o_drop_count,
  output logic [7:0]         o_clear_count,
`endif
  output logic               o_fb_write_en,
  output logic [A_WIDTH-1:0] o_fb_write_addr,
  output logic [D_WIDTH-1:0] o_fb_write_pixel
);

  import vgacpu_pkg::*;

  localparam int PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam logic [A_WIDTH-1:0] LAST = A_WIDTH'(PIXELS - 1);

  arb_state_e         r_state, w_state_nxt;
  logic [A_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [D_WIDTH-1:0] r_colour, w_colour_nxt;
  logic               r_fb_en, w_fb_en_nxt;
  logic [A_WIDTH-1:0] r_fb_addr, w_fb_addr_nxt;
  logic [D_WIDTH-1:0] r_fb_pixel, w_fb_pixel_nxt;

  logic [1:0]         w_req, w_gnt;
  logic               w_arb_en;
  logic [A_WIDTH-1:0] w_sel_addr;
  logic [D_WIDTH-1:0] w_sel_pixel;
  logic               w_oor;
  logic               w_sweep_done;

  assign w_req    = {rast_wr.valid, cpu_wr.valid};
  assign w_arb_en = (r_state == IDLE) && !i_clear_req;

  fb_rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_arb_en),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  assign cpu_wr.ready  = w_gnt[0];
  assign rast_wr.ready = w_gnt[1];

  assign w_sel_addr   = w_gnt[1] ? rast_wr.addr  : cpu_wr.addr;
  assign w_sel_pixel  = w_gnt[1] ? rast_wr.pixel : cpu_wr.pixel;
  assign w_oor        = (|w_gnt) && (w_sel_addr > LAST);
  assign w_sweep_done = (r_state == CLEAR) && (r_cnt == LAST);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_colour_nxt   = r_colour;
    w_fb_en_nxt    = 1'b0;
    w_fb_addr_nxt  = r_fb_addr;
    w_fb_pixel_nxt = r_fb_pixel;
    unique case (r_state)
      IDLE: begin
        if (i_clear_req) begin
          w_state_nxt    = CLEAR;
          w_cnt_nxt      = '0;
          w_colour_nxt   = i_clear_colour;
          w_fb_en_nxt    = 1'b1;
          w_fb_addr_nxt  = '0;
          w_fb_pixel_nxt = i_clear_colour;
        end else if ((|w_gnt) && !w_oor) begin
          w_fb_en_nxt    = 1'b1;
          w_fb_addr_nxt  = w_sel_addr;
          w_fb_pixel_nxt = w_sel_pixel;
        end
      end
      CLEAR: begin
        if (w_sweep_done) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt      = r_cnt + 1'b1;
          w_fb_en_nxt    = 1'b1;
          w_fb_addr_nxt  = r_cnt + 1'b1;
          w_fb_pixel_nxt = r_colour;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_colour   <= '0;
      r_fb_en    <= 1'b0;
      r_fb_addr  <= '0;
      r_fb_pixel <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_colour   <= w_colour_nxt;
      r_fb_en    <= w_fb_en_nxt;
      r_fb_addr  <= w_fb_addr_nxt;
      r_fb_pixel <= w_fb_pixel_nxt;
    end
  end

  assign o_clear_busy     = (r_state == CLEAR);
  assign o_fb_write_en    = r_fb_en;
  assign o_fb_write_addr  = r_fb_addr;
  assign o_fb_write_pixel = r_fb_pixel;

`ifdef VGACPU_FB_ARB_STATS_EN
  logic [15:0] r_drop_count;
  logic [7:0]  r_clear_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_count  <= '0;
      r_clear_count <= '0;
    end else begin
      if (w_oor && (r_drop_count != 16'hFFFF))
        r_drop_count <= r_drop_count + 16'd1;
      if (w_sweep_done)
        r_clear_count <= r_clear_count + 8'd1;
    end
  end

  assign o_drop_count  = r_drop_count;
  assign o_clear_count = r_clear_count;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized bench for fb_write_arbiter against a transaction-level model.
// Honours VGACPU_FB_ARB_STATS_EN for the statistics outputs.
module tb_fb_write_arbiter;
  import vgacpu_pkg::*;

  localparam int N = FB_PIXELS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [2:0]  col = '0;
  logic        busy, fen;
  logic [15:0] faddr;
  logic [2:0]  fpix;
`ifdef VGACPU_FB_ARB_STATS_EN
  logic [15:0] drops;
  logic [7:0]  clears;
`endif

  always #5 clk = ~clk;

  fb_write_arbiter_if cpu_if ();
  fb_write_arbiter_if rast_if ();

  fb_write_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .i_clear_req      (clr),
    .i_clear_colour   (col),
    .o_clear_busy     (busy),
    .cpu_wr           (cpu_if),
    .rast_wr          (rast_if),
`ifdef VGACPU_FB_ARB_STATS_EN
    .o_drop_count     (drops),
    .o_clear_count    (clears),
`endif
    .o_fb_write_en    (fen),
    .o_fb_write_addr  (faddr),
    .o_fb_write_pixel (fpix)
  );

  int n_vec = 0;
  int n_bad = 0;

  // model state: who won last, sweep progress, stats
  bit         m_last_rast = 1'b1;
  int         m_next = 0;
  int         m_left = 0;
  logic [2:0] m_col = '0;
  int         m_drops = 0;
  int         m_clears = 0;

  // expectations for current cycle (e_*) and next cycle (p_*)
  bit         e_crdy, e_rrdy;
  bit         e_en = 0, e_busy = 0;
  int         e_addr = 0;
  logic [2:0] e_pix = '0;
  bit         p_en, p_busy;
  int         p_addr;
  logic [2:0] p_pix;

  // held requester payloads
  int         c_a, r_a;
  logic [2:0] c_p, r_p;

  task automatic drive(bit r, bit c, logic [2:0] cc,
                       bit cv, int ca, logic [2:0] cp,
                       bit rv, int ra, logic [2:0] rp);
    bit pick_r;
    int a;
    logic [2:0] px;
    rst = r; clr = c; col = cc;
    cpu_if.valid = cv; cpu_if.addr = 16'(ca); cpu_if.pixel = cp;
    rast_if.valid = rv; rast_if.addr = 16'(ra); rast_if.pixel = rp;
    #1;
    e_crdy = 0; e_rrdy = 0;
    p_en = 0; p_busy = 0; p_addr = e_addr; p_pix = e_pix;
    if (e_busy) begin
      if (m_left > 0) begin
        p_en = 1; p_busy = 1; p_addr = m_next; p_pix = m_col;
        m_next++; m_left--;
      end else begin
        m_clears = (m_clears + 1) % 256;
      end
    end else if (c) begin
      m_col = cc; m_next = 1; m_left = N - 1;
      p_en = 1; p_busy = 1; p_addr = 0; p_pix = cc;
    end else if (cv || rv) begin
      pick_r = rv && !(cv && m_last_rast);
      e_crdy = !pick_r; e_rrdy = pick_r;
      m_last_rast = pick_r;
      a  = pick_r ? ra : ca;
      px = pick_r ? rp : cp;
      if (a < N) begin
        p_en = 1; p_addr = a; p_pix = px;
      end else if (m_drops < 65535) begin
        m_drops++;
      end
    end
    if (r) begin
      p_en = 0; p_busy = 0; p_addr = 0; p_pix = '0;
      m_last_rast = 1; m_left = 0; m_drops = 0; m_clears = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    e_en = p_en; e_busy = p_busy; e_addr = p_addr; e_pix = p_pix;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    n_vec++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy got %b want 0", busy);
    end
    n_vec++;
    if (fen !== 1'b0 || faddr !== 16'd0 || fpix !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_fb got en=%b a=%0d p=%0d want 0/0/0",
               fen, faddr, fpix);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (cpu_if.ready !== 1'b0 || rast_if.ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready got c=%b r=%b want 0/0",
               cpu_if.ready, rast_if.ready);
    end
    tick();
  endtask

  task automatic test_contention();
    bit want_r [4] = '{0, 1, 0, 1};
    c_a = $urandom_range(0, N - 1); c_p = 3'($urandom);
    r_a = $urandom_range(0, N - 1); r_p = 3'($urandom);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, c_a, c_p, 1, r_a, r_p);
      n_vec++;
      if (rast_if.ready !== want_r[i] || cpu_if.ready !== !want_r[i]) begin
        n_bad++;
        $display("FAIL contention_gnt%0d got c=%b r=%b want r=%b",
                 i, cpu_if.ready, rast_if.ready, want_r[i]);
      end
      tick();
      n_vec++;
      if (fen !== 1'b1 || faddr !== e_addr[15:0] || fpix !== e_pix) begin
        n_bad++;
        $display("FAIL contention_wr%0d got en=%b a=%0d p=%0d want 1/%0d/%0d",
                 i, fen, faddr, fpix, e_addr, e_pix);
      end
      if (want_r[i]) begin
        r_a = $urandom_range(0, N - 1); r_p = 3'($urandom);
      end else begin
        c_a = $urandom_range(0, N - 1); c_p = 3'($urandom);
      end
    end
  endtask

  task automatic test_cpu_only();
    drive(0, 0, 0, 1, 5, 3'b101, 0, 0, 0);
    n_vec++;
    if (cpu_if.ready !== 1'b1 || rast_if.ready !== 1'b0) begin
      n_bad++;
      $display("FAIL cpu_only_ready got c=%b r=%b want 1/0",
               cpu_if.ready, rast_if.ready);
    end
    tick();
    n_vec++;
    if (fen !== 1'b1 || faddr !== 16'd5 || fpix !== 3'd5) begin
      n_bad++;
      $display("FAIL cpu_only_wr got en=%b a=%0d p=%0d want 1/5/5",
               fen, faddr, fpix);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_vec++;
    if (fen !== 1'b0) begin
      n_bad++; $display("FAIL cpu_only_idle got en=%b want 0", fen);
    end
  endtask

  task automatic test_random();
    bit cv, rv;
    cv = 0; rv = 0;
    for (int i = 0; i < 300; i++) begin
      if (!cv) begin
        cv = 1'($urandom);
        c_a = $urandom_range(0, N + 50); c_p = 3'($urandom);
      end
      if (!rv) begin
        rv = 1'($urandom);
        r_a = $urandom_range(0, N + 50); r_p = 3'($urandom);
      end
      drive(0, 0, 0, cv, c_a, c_p, rv, r_a, r_p);
      n_vec++;
      if (cpu_if.ready !== e_crdy || rast_if.ready !== e_rrdy) begin
        n_bad++;
        $display("FAIL random_ready%0d got c=%b r=%b want c=%b r=%b",
                 i, cpu_if.ready, rast_if.ready, e_crdy, e_rrdy);
      end
      if (e_crdy) cv = 0;
      if (e_rrdy) rv = 0;
      tick();
      n_vec++;
      if (fen !== e_en || (e_en && (faddr !== e_addr[15:0] || fpix !== e_pix)))
      begin
        n_bad++;
        $display("FAIL random_wr%0d got en=%b a=%0d p=%0d want %b/%0d/%0d",
                 i, fen, faddr, fpix, e_en, e_addr, e_pix);
      end
    end
  endtask

  task automatic test_out_of_range();
    drive(0, 0, 0, 0, 0, 0, 1, N, 3'b111);
    n_vec++;
    if (rast_if.ready !== 1'b1 || cpu_if.ready !== 1'b0) begin
      n_bad++;
      $display("FAIL oor_ready got r=%b c=%b want 1/0",
               rast_if.ready, cpu_if.ready);
    end
    tick();
    n_vec++;
    if (fen !== 1'b0) begin
      n_bad++; $display("FAIL oor_wr got en=%b want 0", fen);
    end
`ifdef VGACPU_FB_ARB_STATS_EN
    n_vec++;
    if (drops !== 16'(m_drops)) begin
      n_bad++; $display("FAIL oor_drops got %0d want %0d", drops, m_drops);
    end
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_clear_sweep();
    int writes, k;
    c_a = $urandom_range(0, N - 1); c_p = 3'($urandom);
    r_a = $urandom_range(0, N - 1); r_p = 3'($urandom);
    drive(0, 1, 3'b010, 1, c_a, c_p, 1, r_a, r_p);
    n_vec++;
    if (cpu_if.ready !== 1'b0 || rast_if.ready !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_take_ready got c=%b r=%b want 0/0",
               cpu_if.ready, rast_if.ready);
    end
    tick();
    writes = 0; k = 0;
    while (e_busy && k < N + 10) begin
      n_vec++;
      if (busy !== 1'b1 || fen !== 1'b1 ||
          faddr !== e_addr[15:0] || fpix !== e_pix) begin
        n_bad++;
        $display("FAIL sweep_wr%0d got b=%b en=%b a=%0d p=%0d want 1/1/%0d/%0d",
                 k, busy, fen, faddr, fpix, e_addr, e_pix);
      end
      if (fen === 1'b1) writes++;
      drive(0, (k == 500), 3'b101, 1, c_a, c_p, 1, r_a, r_p);
      n_vec++;
      if (cpu_if.ready !== 1'b0 || rast_if.ready !== 1'b0) begin
        n_bad++;
        $display("FAIL sweep_ready%0d got c=%b r=%b want 0/0",
                 k, cpu_if.ready, rast_if.ready);
      end
      tick();
      k++;
    end
    n_vec++;
    if (e_busy || writes != N) begin
      n_bad++;
      $display("FAIL sweep_count got %0d writes want %0d", writes, N);
    end
    n_vec++;
    if (busy !== 1'b0 || fen !== 1'b0) begin
      n_bad++;
      $display("FAIL sweep_end got b=%b en=%b want 0/0", busy, fen);
    end
`ifdef VGACPU_FB_ARB_STATS_EN
    n_vec++;
    if (clears !== 8'(m_clears)) begin
      n_bad++; $display("FAIL sweep_clears got %0d want %0d", clears, m_clears);
    end
`endif
    drive(0, 0, 0, 1, c_a, c_p, 1, r_a, r_p);
    n_vec++;
    if (cpu_if.ready !== e_crdy || rast_if.ready !== e_rrdy) begin
      n_bad++;
      $display("FAIL post_clear_gnt got c=%b r=%b want c=%b r=%b",
               cpu_if.ready, rast_if.ready, e_crdy, e_rrdy);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset_mid_clear();
    int k;
    logic [2:0] cc;
    cc = 3'($urandom);
    drive(0, 1, cc, 0, 0, 0, 0, 0, 0);
    tick();
    k = 0;
    while (!(e_busy && e_addr == 1000) && k < 2000) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      k++;
    end
    n_vec++;
    if (faddr !== 16'd1000 || fpix !== cc || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL midclr_at1000 got a=%0d p=%0d b=%b want 1000/%0d/1",
               faddr, fpix, busy, cc);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_vec++;
    if (busy !== 1'b0 || fen !== 1'b0) begin
      n_bad++;
      $display("FAIL midclr_abort got b=%b en=%b want 0/0", busy, fen);
    end
    c_a = $urandom_range(0, N - 1); c_p = 3'($urandom);
    drive(0, 0, 0, 1, c_a, c_p, 0, 0, 0);
    n_vec++;
    if (cpu_if.ready !== 1'b1) begin
      n_bad++; $display("FAIL midclr_cpu_ready got %b want 1", cpu_if.ready);
    end
    tick();
    n_vec++;
    if (fen !== 1'b1 || faddr !== 16'(c_a) || fpix !== c_p) begin
      n_bad++;
      $display("FAIL midclr_cpu_wr got en=%b a=%0d p=%0d want 1/%0d/%0d",
               fen, faddr, fpix, c_a, c_p);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_cpu_only();
    test_random();
    test_out_of_range();
    test_clear_sweep();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Owns the framebuffer SRAM write port and shares it between two requesters: the CPU (direct pixel pokes) and the rasterizer.
- Contains a built-in clear engine that sweeps every framebuffer word with one colour.
- Sits between the CPU/rasterizer and the framebuffer write-side connections. The VGA output module keeps the read port and does not interact with this block.

Parameters:
- FB_WIDTH, 214, framebuffer width in pixels.
- FB_HEIGHT, 160, framebuffer height in pixels.
- A_WIDTH, 16, framebuffer address width.
- D_WIDTH, 3, pixel width (R,G,B one bit each).

Ports:
- clk  in  1  system clock (50 MHz domain).
- rst  in  1  synchronous active-high reset.
- clear_req  in  1  single-cycle pulse requesting a full-framebuffer clear.
- clear_colour  in  D_WIDTH  fill colour; sampled only when clear_req is taken.
- clear_busy  out  1  high while the clear sweep is in progress.
- cpu_wr_valid  in  1  CPU write request.
- cpu_wr_ready  out  1  CPU request accepted this cycle.
- cpu_wr_addr  in  A_WIDTH  CPU write address.
- cpu_wr_pixel  in  D_WIDTH  CPU write data.
- rast_wr_valid  in  1  rasterizer write request.
- rast_wr_ready  out  1  rasterizer request accepted this cycle.
- rast_wr_addr  in  A_WIDTH  rasterizer write address.
- rast_wr_pixel  in  D_WIDTH  rasterizer write data.
- fb_write_en  out  1  framebuffer write strobe.
- fb_write_addr  out  A_WIDTH  framebuffer write address.
- fb_write_pixel  out  D_WIDTH  framebuffer write data.

Behaviour:
- Reset values: clear_busy=0, fb_write_en=0, fb_write_addr=0, fb_write_pixel=0, FSM=IDLE, sweep counter=0, round-robin pointer="rasterizer last", so the CPU wins the first contention.
- FSM states: IDLE, CLEAR.
- IDLE -> CLEAR when clear_req=1. Latch clear_colour. Counter=0.
- In CLEAR, clear_req is ignored.
- CLEAR -> IDLE after the write of address FB_WIDTH*FB_HEIGHT-1 (34239 at defaults).
- Handshake:
  - valid/ready. A transfer occurs on a cycle with valid&&ready.
  - ready is combinational from valid, FSM state and pointer.
  - ready never asserts without the matching valid.
  - Requesters hold addr/pixel stable while valid is high and not yet accepted.
- Arbitration (IDLE only):
  - One valid: grant it.
  - Both valid: grant the one not granted most recently. The pointer updates only on a grant.
  - At most one ready per cycle.
- clear_req precedence: if clear_req=1 in the same cycle as valid requests, clear wins. Both readies=0 that cycle.
- In CLEAR: both readies=0.
- Write latency:
  - A transfer accepted on cycle N appears on cycle N+1 as fb_write_en=1 with the registered addr/pixel.
  - fb_write_en=0 on any cycle following no transfer and no sweep step.
  - Throughput: one write per cycle, back-to-back.
- Clear timing:
  - clear_req taken at edge E.
  - Cycles E+1..E+34240: clear_busy=1, fb_write_en=1, address 0,1,...,34239 incrementing by 1, pixel = latched colour.
  - Cycle E+34241: clear_busy=0; readies may assert.
- Range check:
  - A requester address >= FB_WIDTH*FB_HEIGHT is still accepted (ready per the arbitration rules).
  - The next-cycle fb_write_en stays 0, so nothing is written.
- Reset mid-clear: the sweep aborts immediately. Outputs return to reset values on the next cycle. Words already swept keep the fill colour.
- Counter width: A_WIDTH, with no wrap past the last pixel.

Optional Feature:
- Macro: VGACPU_FB_ARB_STATS_EN.
- Defined:
  - Adds outputs drop_count (16 bits) and clear_count (8 bits), both reset to 0.
  - drop_count increments on each accepted out-of-range request and saturates at 0xFFFF.
  - clear_count increments on each sweep completion and wraps.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package vgacpu_pkg holds:
  - constants FB_WIDTH, FB_HEIGHT, FB_PIXELS (=FB_WIDTH*FB_HEIGHT);
  - typedefs fb_addr_t (logic [15:0]) and pixel_t (logic [2:0], {r,g,b}).
- One sub-module, fb_rr_arbiter2:
  - two-requester round-robin grant logic plus pointer register;
  - enable input gated low during CLEAR or a clear_req.

Test Plan:
- Reset, then CPU only: cpu valid, addr 0x0005, pixel 3'b101 on cycle N -> cpu_wr_ready=1 at N; fb_write_en=1, addr 5, pixel 5 at N+1; rast_wr_ready=0 throughout.
- Both valid continuously for 4 cycles -> grants CPU, RAST, CPU, RAST; 4 consecutive fb writes with matching addr/pixel one cycle later.
- clear_req with colour 3'b010 while both valid -> no ready that cycle or during the sweep; 34240 consecutive writes addr 0..34239, pixel 2; clear_busy drops on the following cycle; the CPU is then granted first.
- Out-of-range: rast addr 34240 -> rast_wr_ready=1; no fb_write_en next cycle. With VGACPU_FB_ARB_STATS_EN: drop_count=1.
- rst asserted at sweep address 1000 -> next cycle clear_busy=0, fb_write_en=0; a subsequent CPU write proceeds normally.
- clear_req pulsed again mid-sweep -> ignored; exactly 34240 writes occur; clear_count=1 (when enabled).
